// File: rtl/fgp_tx.sv
// fgp_tx: builds one FGP frame payload (offset byte + packed colours)
// from the video cache RAM, pulled out one byte per readclk request.
module fgp_tx #(
  parameter int RAM_SIZE            = 16384,
  parameter int RAM_READ_LATENCY    = 2,
  parameter int COLOR_LEN           = 12,
  parameter int BYTE_LEN            = 8,
  parameter int FGP_DATA_LEN_COLORS = 512,
  localparam int AW = $clog2(RAM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BYTE_LEN-1:0]  offset,
  input  logic                 readclk,
  output logic                 ram_readclk,
  output logic [AW-1:0]        ram_raddr,
  input  logic                 ram_outclk,
  input  logic [COLOR_LEN-1:0] ram_out,
  output logic                 outclk,
  output logic [BYTE_LEN-1:0]  out,
  output logic                 done
);

  localparam int DATA_BYTES =
    FGP_DATA_LEN_COLORS * COLOR_LEN / BYTE_LEN;
  localparam int ACC_W = COLOR_LEN + BYTE_LEN - 1;
  localparam int NBW   = $clog2(ACC_W + 1);
  localparam int CW    = $clog2(FGP_DATA_LEN_COLORS + 1);
  localparam int BCW   = $clog2(DATA_BYTES + 1);
  localparam int LW    = $clog2(RAM_READ_LATENCY + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFSET,
    S_DATA,
    S_FIN
  } state_t;

  state_t              r_state;
  logic [BYTE_LEN-1:0] r_offset;
  logic [AW-1:0]       r_base;
  logic [ACC_W-1:0]    r_acc;
  logic [NBW-1:0]      r_nbits;
  logic [CW-1:0]       r_issued;
  logic [BCW-1:0]      r_sent;
  logic                r_req;
  logic                r_busy;
  logic [LW-1:0]       r_blank;

  logic                w_active;
  logic                w_req;
  logic                w_avail;
  logic                w_emit;
  logic                w_emit_data;
  logic                w_last;
  logic                w_fill;
  logic                w_issue;
  logic [NBW-1:0]      w_sh;
  logic [ACC_W-1:0]    w_shifted;
  logic [BYTE_LEN-1:0] w_byte;

  // Byte availability, request matching and read-issue decisions.
  always_comb begin
    w_active    = (r_state == S_OFFSET) || (r_state == S_DATA);
    w_req       = w_active && (r_req || readclk);
    w_avail     = (r_state == S_OFFSET) ||
                  ((r_state == S_DATA) &&
                   (r_nbits >= NBW'(BYTE_LEN)));
    w_emit      = w_req && w_avail;
    w_emit_data = w_emit && (r_state == S_DATA);
    w_sh        = r_nbits - NBW'(BYTE_LEN);
    w_shifted   = r_acc >> w_sh;
    w_byte      = (r_state == S_OFFSET) ?
                  r_offset : w_shifted[BYTE_LEN-1:0];
    w_last      = (r_sent == BCW'(DATA_BYTES - 1));
    w_fill      = ram_outclk && r_busy;
    // r_blank keeps a new read from overlapping the reply of a read
    // aborted by start, so that reply can never be mistaken for ours.
    w_issue     = (r_state == S_DATA) && !r_busy &&
                  (r_blank == '0) &&
                  (r_issued < CW'(FGP_DATA_LEN_COLORS)) &&
                  (r_nbits <= NBW'(BYTE_LEN - 1));
  end

  // Frame FSM, RAM reader, bit accumulator and byte handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_offset    <= '0;
      r_base      <= '0;
      r_acc       <= '0;
      r_nbits     <= '0;
      r_issued    <= '0;
      r_sent      <= '0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_blank     <= '0;
      ram_readclk <= 1'b0;
      ram_raddr   <= '0;
      outclk      <= 1'b0;
      out         <= '0;
      done        <= 1'b0;
    end else begin
      outclk      <= 1'b0;
      done        <= 1'b0;
      ram_readclk <= 1'b0;
      if (start) begin
        r_state  <= S_OFFSET;
        r_offset <= offset;
        r_base   <= AW'(offset) * AW'(FGP_DATA_LEN_COLORS);
        r_acc    <= '0;
        r_nbits  <= '0;
        r_issued <= '0;
        r_sent   <= '0;
        r_req    <= 1'b0;
        r_busy   <= 1'b0;
        r_blank  <= LW'(RAM_READ_LATENCY);
      end else begin
        if (r_blank != '0)
          r_blank <= r_blank - LW'(1);
        unique case (r_state)
          S_IDLE: begin
          end
          S_FIN: begin
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
          default: begin
            if (w_emit) begin
              outclk <= 1'b1;
              out    <= w_byte;
              r_req  <= 1'b0;
              if (r_state == S_OFFSET) begin
                r_state <= S_DATA;
              end else begin
                r_sent <= r_sent + BCW'(1);
                if (w_last)
                  r_state <= S_FIN;
              end
            end else if (readclk) begin
              r_req <= 1'b1;
            end
            if (w_issue) begin
              ram_readclk <= 1'b1;
              ram_raddr   <= r_base + AW'(r_issued);
              r_issued    <= r_issued + CW'(1);
              r_busy      <= 1'b1;
            end else if (w_fill) begin
              r_busy <= 1'b0;
            end
            if (w_fill)
              r_acc <= {r_acc[ACC_W-COLOR_LEN-1:0], ram_out};
            if (w_fill && !w_emit_data)
              r_nbits <= r_nbits + NBW'(COLOR_LEN);
            else if (!w_fill && w_emit_data)
              r_nbits <= r_nbits - NBW'(BYTE_LEN);
            else if (w_fill && w_emit_data)
              r_nbits <= r_nbits + NBW'(COLOR_LEN - BYTE_LEN);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fgp_tx.sv
// tb_fgp_tx: directed frames against a bit-stream model of the payload
// and a latency-2 RAM responder that can be stalled.
module tb_fgp_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  offset = '0;
  logic        readclk = 1'b0;
  logic        ram_readclk;
  logic [13:0] ram_raddr;
  logic        ram_outclk = 1'b0;
  logic [11:0] ram_out = '0;
  logic        outclk;
  logic [7:0]  out;
  logic        done;

  int total = 0;
  int bad = 0;

  fgp_tx dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .offset      (offset),
    .readclk     (readclk),
    .ram_readclk (ram_readclk),
    .ram_raddr   (ram_raddr),
    .ram_outclk  (ram_outclk),
    .ram_out     (ram_out),
    .outclk      (outclk),
    .out         (out),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // RAM contents, selectable pattern
  int pat = 0;
  function automatic logic [11:0] ram_val(input int a);
    int v;
    if (pat == 0) v = a;
    else v = (a * 37) ^ (a >> 5) ^ 'h5A5;
    return v[11:0];
  endfunction

  // RAM responder: data valid 2 cycles after the strobe cycle
  bit          ram_stall = 0;
  int          tcyc = 0;
  logic [13:0] qa[$];
  int          qd[$];
  always @(posedge clk) begin
    tcyc++;
    ram_outclk <= 1'b0;
    if (ram_readclk === 1'b1) begin
      qa.push_back(ram_raddr);
      qd.push_back(tcyc + 1);
    end
    if (qa.size() > 0 && qd[0] <= tcyc && !ram_stall) begin
      ram_outclk <= 1'b1;
      ram_out    <= ram_val(int'(qa[0]));
      qa.delete(0);
      qd.delete(0);
    end
  end

  // payload model
  logic [7:0] exp_q[$];
  bit         mon_en = 0;
  bit         active = 0;
  bit         done_due = 0;
  bit         frame_done = 0;
  int         base_m = 0;
  int         rd_idx = 0;
  int         frame_bytes = 0;
  int         oc_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] last_out = '0;
  logic [7:0] first_out = '0;
  int         first_raddr = -1;
  int         last_raddr = -1;

  task automatic build(input logic [7:0] off);
    bit         bq[$];
    logic [11:0] c;
    logic [7:0]  v;
    exp_q.delete();
    exp_q.push_back(off);
    base_m = (int'(off) * 512) % 16384;
    for (int i = 0; i < 512; i++) begin
      c = ram_val((base_m + i) % 16384);
      for (int b = 11; b >= 0; b--) bq.push_back(c[b]);
    end
    for (int k = 0; k < bq.size(); k += 8) begin
      v = '0;
      for (int j = 0; j < 8; j++) v = {v[6:0], bq[k+j]};
      exp_q.push_back(v);
    end
    active = 1;
    done_due = 0;
    frame_done = 0;
    rd_idx = 0;
    frame_bytes = 0;
    first_raddr = -1;
    last_raddr = -1;
  endtask

  task automatic model_idle();
    exp_q.delete();
    active = 0;
    done_due = 0;
    last_out = '0;
  endtask

  // single compare process
  always @(negedge clk) begin
    if (mon_en) begin
      chk("done", done, done_due);
      if (done) begin
        done_cnt++;
        frame_done = 1;
        chk("reads_per_frame", rd_idx, 512);
      end
      if (done_due) active = 0;
      done_due = 0;
      if (outclk) begin
        oc_cnt++;
        if (active && exp_q.size() > 0) begin
          if (frame_bytes == 0) first_out = out;
          chk("out_byte", out, exp_q[0]);
          exp_q.delete(0);
          frame_bytes++;
          if (exp_q.size() == 0) done_due = 1;
        end else begin
          chk("outclk_spurious", outclk, 0);
        end
        last_out = out;
      end else begin
        chk("out_hold", out, last_out);
      end
      if (ram_readclk) begin
        if (active) begin
          if (rd_idx == 0) first_raddr = int'(ram_raddr);
          last_raddr = int'(ram_raddr);
          chk("raddr", ram_raddr, (base_m + rd_idx) % 16384);
          rd_idx++;
        end else begin
          chk("readclk_idle", ram_readclk, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] off);
    readclk = 0;
    offset = off;
    start = 1;
    tick();
    start = 0;
    build(off);
  endtask

  task automatic run_frame(input int period, input int max_bytes);
    int cyc = 0;
    while (!frame_done && frame_bytes < max_bytes && cyc < 10000) begin
      readclk = (cyc % period == 0);
      tick();
      cyc++;
    end
    readclk = 0;
    chk("frame_budget", cyc < 10000, 1);
  endtask

  task automatic full_frame(input logic [7:0] off, input int period);
    do_start(off);
    run_frame(period, 100000);
    chk("frame_done", frame_done, 1);
    chk("frame_bytes", frame_bytes, 769);
    chk("first_byte", first_out, off);
  endtask

  initial begin
    logic [7:0] pin [7] = '{8'h03, 8'h60, 8'h06, 8'h01,
                            8'h60, 8'h26, 8'h03};
    int n0;
    int d0;
    bit found;
    bit est;

    repeat (3) tick();
    chk("rst_outclk", outclk, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_readclk", ram_readclk, 0);
    chk("rst_out", out, 0);
    chk("rst_ram_raddr", ram_raddr, 0);
    rst = 0;
    model_idle();
    mon_en = 1;
    repeat (3) tick();

    // frame at offset 3, RAM[a]=a, readclk every 4 cycles
    pat = 0;
    do_start(8'h03);
    chk("model_len", exp_q.size(), 769);
    chk("model_base", base_m, 'h600);
    for (int i = 0; i < 7; i++) chk("model_pin", exp_q[i], pin[i]);
    run_frame(4, 100000);
    chk("f1_done", frame_done, 1);
    chk("f1_bytes", frame_bytes, 769);
    chk("f1_first_out", first_out, 8'h03);
    chk("f1_first_raddr", first_raddr, 'h600);
    repeat (4) tick();

    // readclk held high, then ignored in IDLE
    pat = 1;
    full_frame(8'h04, 1);
    n0 = oc_cnt;
    readclk = 1;
    repeat (10) tick();
    readclk = 0;
    chk("idle_readclk_ignored", oc_cnt, n0);

    // top of RAM and offset truncation
    full_frame(8'd31, 2);
    chk("top_first_raddr", first_raddr, 'h3E00);
    chk("top_last_raddr", last_raddr, 'h3FFF);
    pat = 0;
    full_frame(8'h22, 3);
    chk("trunc_first_raddr", first_raddr, 'h400);

    // abort after 100 bytes while a read is in flight
    pat = 1;
    do_start(8'h05);
    run_frame(4, 100);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (ram_readclk) found = 1;
      else begin
        readclk = (k % 4 == 0);
        tick();
      end
    end
    chk("abort_strobe_seen", found, 1);
    d0 = done_cnt;
    full_frame(8'h09, 4);
    chk("abort_one_done", done_cnt, d0 + 1);

    // stalled RAM with a pending request and dropped extra requests
    do_start(8'h07);
    run_frame(4, 50);
    ram_stall = 1;
    est = 0;
    for (int k = 0; k < 12 && !est; k++) begin
      n0 = oc_cnt;
      readclk = 1;
      tick();
      readclk = 0;
      repeat (6) tick();
      if (oc_cnt == n0) est = 1;
    end
    chk("stall_pending", est, 1);
    n0 = oc_cnt;
    readclk = 1; tick(); readclk = 0; tick();
    readclk = 1; tick(); readclk = 0;
    repeat (10) tick();
    chk("stall_no_out", oc_cnt, n0);
    ram_stall = 0;
    repeat (20) tick();
    chk("stall_one_out", oc_cnt, n0 + 1);
    run_frame(4, 100000);
    chk("stall_frame_done", frame_done, 1);
    chk("stall_frame_bytes", frame_bytes, 769);

    // reset mid-frame
    pat = 0;
    do_start(8'h0B);
    run_frame(4, 60);
    rst = 1;
    tick();
    chk("mid_rst_outclk", outclk, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ram_readclk", ram_readclk, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_ram_raddr", ram_raddr, 0);
    model_idle();
    rst = 0;
    n0 = oc_cnt;
    d0 = done_cnt;
    for (int k = 0; k < 20; k++) begin
      readclk = (k % 2 == 0);
      tick();
    end
    readclk = 0;
    chk("post_rst_no_out", oc_cnt, n0);
    chk("post_rst_no_done", done_cnt, d0);

    // recovery
    full_frame(8'h0C, 4);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
